cache_mem_arbiter: RTL and testbench

- Shares the single multi-cycle main-memory port between the I-cache fill FSM and the D-cache side (D-cache fill FSM plus write-through stores).
- Grants one owner at a time and muxes that owner's address, enable and write data onto memory.
- Routes returned data-valid beats to the owner only.
- Holds a fill grant until the full block of beats has returned, so two fills never interleave on the memory bus.

---
 rtl/cache_arb_pkg.sv | 29 ++
 rtl/cache_mem_arbiter_beat_counter.sv | 47 ++++
 rtl/cache_mem_arbiter.sv | 158 +++++++++++++++
 tb/tb_cache_mem_arbiter.sv | 359 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_arb_pkg.sv
// -----------------------------------------------------------------------------
// cache_arb_pkg
// Shared types and constants for the cache main-memory arbiter.
//   arb_state_e : arbiter FSM state encoding
//   arb_side_e  : which client was served last (round-robin bookkeeping)
//   WORDS_PER_BLOCK_DEF : default number of beats per cache-block fill
//   cnt_width() : beat-counter width, never less than one bit
// -----------------------------------------------------------------------------
package cache_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    IFILL  = 2'b01,
    DFILL  = 2'b10,
    DWRITE = 2'b11
  } arb_state_e;

  typedef enum logic {
    SIDE_I = 1'b0,
    SIDE_D = 1'b1
  } arb_side_e;

  localparam int unsigned WORDS_PER_BLOCK_DEF = 8;

  function automatic int unsigned cnt_width(input int unsigned words);
    return (words > 1) ? $clog2(words) : 1;
  endfunction

endpackage

// File: rtl/cache_mem_arbiter_beat_counter.sv
// -----------------------------------------------------------------------------
// arb_beat_counter
// Counts returned data beats of the fill in progress.
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   clr_i    : return the count to zero (wins over inc_i)
//   inc_i    : advance the count by one
//   tc_o     : count currently equals WORDS_PER_BLOCK-1 (next beat is last)
// -----------------------------------------------------------------------------
module arb_beat_counter
  import cache_arb_pkg::*;
#(
  parameter int unsigned WORDS_PER_BLOCK = WORDS_PER_BLOCK_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic inc_i,
  output logic tc_o
);

  localparam int unsigned CNT_W = cnt_width(WORDS_PER_BLOCK);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WORDS_PER_BLOCK - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_o = (cnt_q == LAST);

endmodule

// File: rtl/cache_mem_arbiter.sv
// -----------------------------------------------------------------------------
// cache_mem_arbiter
// Shares one multi-cycle main-memory port between the I-cache fill FSM and the
// D-cache side (fills and write-through stores). One owner at a time; a fill
// grant is held until all WORDS_PER_BLOCK beats have returned.
//
// Build option: define ARB_ROUND_ROBIN_EN to alternate between I and D when
// both request in the same IDLE cycle; otherwise D has fixed priority.
//
// Ports:
//   clk, rst                      : clock, synchronous active-high reset
//   i_req, i_addr, i_en           : I-side fill request, word address, strobe
//   d_req, d_wr, d_addr, d_en,
//   d_wdata                       : D-side request (wr=1 store, 0 fill)
//   i_gnt, d_gnt                  : ownership indications
//   i_data_valid, d_data_valid    : returned beat routed to the owner
//   rdata                         : mem_rdata passthrough
//   mem_addr, mem_en, mem_wr,
//   mem_wdata                     : memory request side
//   mem_rdata, mem_data_valid     : memory return side
// -----------------------------------------------------------------------------
module cache_mem_arbiter
  import cache_arb_pkg::*;
#(
  parameter int unsigned WORDS_PER_BLOCK = WORDS_PER_BLOCK_DEF,
  parameter int unsigned ADDR_W          = 16,
  parameter int unsigned DATA_W          = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic              i_en,
  input  logic              d_req,
  input  logic              d_wr,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic              d_en,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              i_gnt,
  output logic              d_gnt,
  output logic              i_data_valid,
  output logic              d_data_valid,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_en,
  output logic              mem_wr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_data_valid
);

  arb_state_e state_q, state_d;
  arb_side_e  last_q, last_d;

  logic fill_active;
  logic beat_inc;
  logic beat_tc;
  logic beat_last;

  assign fill_active = (state_q == IFILL) || (state_q == DFILL);
  assign beat_inc    = mem_data_valid && fill_active;
  assign beat_last   = beat_inc && beat_tc;

  arb_beat_counter #(
    .WORDS_PER_BLOCK(WORDS_PER_BLOCK)
  ) u_beat_counter (
    .clk  (clk),
    .rst  (rst),
    .clr_i(beat_last),
    .inc_i(beat_inc),
    .tc_o (beat_tc)
  );

  // Next-state: arbitration only happens in IDLE; owning states ignore req.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    case (state_q)
      IDLE: begin
`ifdef ARB_ROUND_ROBIN_EN
        // On contention the side served last yields.
        if (d_req && (!i_req || (last_q == SIDE_I))) begin
          state_d = d_wr ? DWRITE : DFILL;
        end else if (i_req) begin
          state_d = IFILL;
        end
`else
        if (d_req) begin
          state_d = d_wr ? DWRITE : DFILL;
        end else if (i_req) begin
          state_d = IFILL;
        end
`endif
        if (state_d == IFILL) begin
          last_d = SIDE_I;
        end else if (state_d != IDLE) begin
          last_d = SIDE_D;
        end
      end
      IFILL, DFILL: begin
        // Always return through IDLE, giving one bubble between grants.
        if (beat_last) begin
          state_d = IDLE;
        end
      end
      DWRITE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      last_q  <= SIDE_D;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
    end
  end

  // Memory-side mux: only the owner's controls ever reach memory.
  always_comb begin
    mem_addr  = '0;
    mem_en    = 1'b0;
    mem_wr    = 1'b0;
    mem_wdata = '0;
    case (state_q)
      IFILL: begin
        mem_addr = i_addr;
        mem_en   = i_en;
      end
      DFILL: begin
        mem_addr = d_addr;
        mem_en   = d_en;
      end
      DWRITE: begin
        mem_addr  = d_addr;
        mem_en    = 1'b1;
        mem_wr    = 1'b1;
        mem_wdata = d_wdata;
      end
      default: begin
        mem_addr  = '0;
      end
    endcase
  end

  assign i_gnt        = (state_q == IFILL);
  assign d_gnt        = (state_q == DFILL) || (state_q == DWRITE);
  assign i_data_valid = mem_data_valid && (state_q == IFILL);
  assign d_data_valid = mem_data_valid && (state_q == DFILL);
  assign rdata        = mem_rdata;

endmodule

// File: tb/tb_cache_mem_arbiter.sv
module tb_cache_mem_arbiter;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 16;
  localparam int WPB    = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              i_req, i_en, d_req, d_wr, d_en;
  logic [ADDR_W-1:0] i_addr, d_addr;
  logic [DATA_W-1:0] d_wdata, mem_rdata;
  logic              mem_data_valid;
  logic              i_gnt, d_gnt, i_data_valid, d_data_valid;
  logic [DATA_W-1:0] rdata, mem_wdata;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_en, mem_wr;

  int total = 0;
  int bad   = 0;
  int i_dv_cnt = 0;
  int d_dv_cnt = 0;

  // Scoreboard entry: {owner is D, expected rdata}
  logic [DATA_W:0] exp_q[$];
  logic [DATA_W:0] mon_exp;

  always #5 clk = ~clk;

  cache_mem_arbiter #(
    .WORDS_PER_BLOCK(WPB),
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_en(i_en),
    .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_en(d_en), .d_wdata(d_wdata),
    .i_gnt(i_gnt), .d_gnt(d_gnt),
    .i_data_valid(i_data_valid), .d_data_valid(d_data_valid),
    .rdata(rdata),
    .mem_addr(mem_addr), .mem_en(mem_en), .mem_wr(mem_wr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_data_valid(mem_data_valid)
  );

  // Every routed beat must match the next scoreboard entry; unexpected beats fail.
  always @(negedge clk) begin
    if (i_data_valid || d_data_valid) begin
      if (i_data_valid) i_dv_cnt++;
      if (d_data_valid) d_dv_cnt++;
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL dv_unexpected: i_dv=%b d_dv=%b rdata=%h, required no data_valid",
                 i_data_valid, d_data_valid, rdata);
      end else begin
        mon_exp = exp_q.pop_front();
        if ({d_data_valid, i_data_valid, rdata} !==
            {mon_exp[DATA_W], ~mon_exp[DATA_W], mon_exp[DATA_W-1:0]}) begin
          bad++;
          $display("FAIL dv_route: d_dv=%b i_dv=%b rdata=%h, required d_dv=%b i_dv=%b rdata=%h",
                   d_data_valid, i_data_valid, rdata,
                   mon_exp[DATA_W], ~mon_exp[DATA_W], mon_exp[DATA_W-1:0]);
        end
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Wait lat cycles, then drive WPB back-to-back beats for the owner; checks
  // the grant is held on every beat and that both grants are low afterwards.
  task automatic fill_beats(input logic side_d, input int lat, input logic [DATA_W-1:0] base);
    logic [DATA_W-1:0] w;
    repeat (lat) tick();
    for (int k = 0; k < WPB; k++) begin
      w = base + DATA_W'(k);
      mem_data_valid = 1'b1;
      mem_rdata      = w;
      exp_q.push_back({side_d, w});
      @(negedge clk);
      total++;
      if ((side_d ? d_gnt : i_gnt) !== 1'b1) begin
        bad++;
        $display("FAIL gnt_hold beat %0d: gnt=%b, required 1", k, side_d ? d_gnt : i_gnt);
      end
      tick();
    end
    mem_data_valid = 1'b0;
    @(negedge clk);
    total++;
    if ({i_gnt, d_gnt, mem_en} !== 3'b000) begin
      bad++;
      $display("FAIL gnt_drop: i_gnt=%b d_gnt=%b mem_en=%b, required 000", i_gnt, d_gnt, mem_en);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick();
    tick();
    mem_data_valid = 1'b1;
    mem_rdata      = 16'h1234;
    @(negedge clk);
    total++;
    if ({i_gnt, d_gnt, i_data_valid, d_data_valid} !== 4'b0000) begin
      bad++;
      $display("FAIL reset_flags: gnt/dv=%b, required 0000", {i_gnt, d_gnt, i_data_valid, d_data_valid});
    end
    total++;
    if ({mem_en, mem_wr, mem_addr, mem_wdata} !== '0) begin
      bad++;
      $display("FAIL reset_mem: en=%b wr=%b addr=%h wdata=%h, required all 0", mem_en, mem_wr, mem_addr, mem_wdata);
    end
    total++;
    if (rdata !== 16'h1234) begin
      bad++;
      $display("FAIL reset_rdata: rdata=%h, required 1234", rdata);
    end
    tick();
    rst = 1'b0;
    mem_data_valid = 1'b0;
  endtask

  task automatic test_priority;
    logic first_d;
    first_d = 1'b1;
`ifdef ARB_ROUND_ROBIN_EN
    first_d = 1'b0;
`endif
    i_req = 1'b1; i_en = 1'b1; i_addr = 16'h0200;
    d_req = 1'b1; d_wr = 1'b0; d_en = 1'b1; d_addr = 16'h0300;
    tick();
    if (first_d) d_req = 1'b0; else i_req = 1'b0;
    @(negedge clk);
    total++;
    if ({i_gnt, d_gnt} !== (first_d ? 2'b01 : 2'b10)) begin
      bad++;
      $display("FAIL prio_first: i_gnt=%b d_gnt=%b, required first_d=%b", i_gnt, d_gnt, first_d);
    end
    total++;
    if (mem_addr !== (first_d ? 16'h0300 : 16'h0200)) begin
      bad++;
      $display("FAIL prio_addr: mem_addr=%h, required %h", mem_addr, first_d ? 16'h0300 : 16'h0200);
    end
    fill_beats(first_d, 4, 16'hB000);
    tick();
    if (first_d) i_req = 1'b0; else d_req = 1'b0;
    @(negedge clk);
    total++;
    if ({i_gnt, d_gnt} !== (first_d ? 2'b10 : 2'b01)) begin
      bad++;
      $display("FAIL prio_second: i_gnt=%b d_gnt=%b, required first_d=%b", i_gnt, d_gnt, first_d);
    end
    fill_beats(~first_d, 2, 16'hC000);
    i_en = 1'b0; d_en = 1'b0;
  endtask

  task automatic test_ifill;
    int ib, db;
    ib = i_dv_cnt; db = d_dv_cnt;
    i_req = 1'b1; i_en = 1'b1; i_addr = 16'h0100;
    tick();
    i_req = 1'b0;
    @(negedge clk);
    total++;
    if ({i_gnt, d_gnt, mem_en, mem_wr} !== 4'b1010 || mem_addr !== 16'h0100) begin
      bad++;
      $display("FAIL ifill_grant: i_gnt=%b d_gnt=%b en=%b wr=%b addr=%h, required 1 0 1 0 0100",
               i_gnt, d_gnt, mem_en, mem_wr, mem_addr);
    end
    fill_beats(1'b0, 4, 16'hA000);
    total++;
    if (i_dv_cnt - ib != WPB || d_dv_cnt != db) begin
      bad++;
      $display("FAIL ifill_counts: i_dv=%0d d_dv=%0d, required %0d 0", i_dv_cnt - ib, d_dv_cnt - db, WPB);
    end
    i_en = 1'b0;
  endtask

  task automatic test_write;
    d_req = 1'b1; d_wr = 1'b1; d_addr = 16'h00A4; d_wdata = 16'hBEEF;
    tick();
    d_req = 1'b0; d_wr = 1'b0;
    mem_data_valid = 1'b1; mem_rdata = 16'hDEAD;
    @(negedge clk);
    total++;
    if ({d_gnt, mem_en, mem_wr} !== 3'b111 || mem_addr !== 16'h00A4 || mem_wdata !== 16'hBEEF) begin
      bad++;
      $display("FAIL write_cycle: gnt=%b en=%b wr=%b addr=%h wdata=%h, required 1 1 1 00A4 BEEF",
               d_gnt, mem_en, mem_wr, mem_addr, mem_wdata);
    end
    tick();
    mem_data_valid = 1'b0;
    @(negedge clk);
    total++;
    if ({d_gnt, mem_en, mem_wr} !== 3'b000 || mem_addr !== '0 || mem_wdata !== '0) begin
      bad++;
      $display("FAIL write_after: gnt=%b en=%b wr=%b addr=%h wdata=%h, required all 0",
               d_gnt, mem_en, mem_wr, mem_addr, mem_wdata);
    end
  endtask

  task automatic test_persist;
    logic [DATA_W-1:0] w;
    i_req = 1'b1; i_en = 1'b1; i_addr = 16'h0400;
    d_wr = 1'b0; d_en = 1'b1; d_addr = 16'h0DDD;
    tick();
    @(negedge clk);
    total++;
    if (i_gnt !== 1'b1) begin
      bad++;
      $display("FAIL persist_grant: i_gnt=%b, required 1", i_gnt);
    end
    repeat (2) tick();
    for (int k = 0; k < WPB; k++) begin
      w = 16'hD000 + DATA_W'(k);
      mem_data_valid = 1'b1;
      mem_rdata = w;
      exp_q.push_back({1'b0, w});
      i_addr = 16'h0400 + ADDR_W'(k);
      i_en   = k[0];
      d_req  = (k == 1) || (k >= 5);
      if (k == 2) i_req = 1'b0;
      @(negedge clk);
      total++;
      if ({i_gnt, d_gnt} !== 2'b10 || mem_addr !== 16'h0400 + ADDR_W'(k) || mem_en !== k[0]) begin
        bad++;
        $display("FAIL persist_beat %0d: i_gnt=%b d_gnt=%b addr=%h en=%b, required 1 0 %h %b",
                 k, i_gnt, d_gnt, mem_addr, mem_en, 16'h0400 + ADDR_W'(k), k[0]);
      end
      tick();
    end
    mem_data_valid = 1'b0;
    @(negedge clk);
    total++;
    if ({i_gnt, d_gnt} !== 2'b00) begin
      bad++;
      $display("FAIL persist_bubble: i_gnt=%b d_gnt=%b, required 00", i_gnt, d_gnt);
    end
    tick();
    d_req = 1'b0;
    @(negedge clk);
    total++;
    if (d_gnt !== 1'b1 || mem_addr !== 16'h0DDD) begin
      bad++;
      $display("FAIL persist_dnext: d_gnt=%b addr=%h, required 1 0DDD", d_gnt, mem_addr);
    end
    fill_beats(1'b1, 1, 16'hE000);
    i_en = 1'b0; d_en = 1'b0;
  endtask

  task automatic test_rst_midfill;
    logic [DATA_W-1:0] w;
    d_req = 1'b1; d_wr = 1'b0; d_en = 1'b1; d_addr = 16'h0500;
    tick();
    d_req = 1'b0;
    @(negedge clk);
    total++;
    if (d_gnt !== 1'b1) begin
      bad++;
      $display("FAIL rstmid_grant: d_gnt=%b, required 1", d_gnt);
    end
    tick();
    for (int k = 0; k < 3; k++) begin
      w = 16'h5000 + DATA_W'(k);
      mem_data_valid = 1'b1;
      mem_rdata = w;
      exp_q.push_back({1'b1, w});
      tick();
    end
    mem_data_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    total++;
    if ({i_gnt, d_gnt, mem_en} !== 3'b000) begin
      bad++;
      $display("FAIL rstmid_after: i_gnt=%b d_gnt=%b en=%b, required 000", i_gnt, d_gnt, mem_en);
    end
    for (int k = 0; k < WPB - 3; k++) begin
      mem_data_valid = 1'b1;
      mem_rdata = 16'h5F00 + DATA_W'(k);
      tick();
    end
    mem_data_valid = 1'b0;
    d_en = 1'b0;
    i_req = 1'b1; i_en = 1'b1; i_addr = 16'h0600;
    tick();
    i_req = 1'b0;
    @(negedge clk);
    total++;
    if (i_gnt !== 1'b1) begin
      bad++;
      $display("FAIL rstmid_igrant: i_gnt=%b, required 1", i_gnt);
    end
    fill_beats(1'b0, 1, 16'hF000);
    i_en = 1'b0;
  endtask

  task automatic test_stray;
    for (int k = 0; k < 3; k++) begin
      mem_data_valid = 1'b1;
      mem_rdata = 16'h7700 + DATA_W'(k);
      tick();
    end
    mem_data_valid = 1'b0;
    d_req = 1'b1; d_wr = 1'b1; d_addr = 16'h0042; d_wdata = 16'h1111;
    tick();
    d_req = 1'b0; d_wr = 1'b0;
    mem_data_valid = 1'b1;
    @(negedge clk);
    total++;
    if ({d_gnt, mem_wr, d_data_valid} !== 3'b110) begin
      bad++;
      $display("FAIL stray_write: d_gnt=%b wr=%b d_dv=%b, required 1 1 0", d_gnt, mem_wr, d_data_valid);
    end
    tick();
    mem_data_valid = 1'b0;
    i_req = 1'b1; i_en = 1'b1; i_addr = 16'h0700;
    tick();
    i_req = 1'b0;
    @(negedge clk);
    total++;
    if (i_gnt !== 1'b1) begin
      bad++;
      $display("FAIL stray_igrant: i_gnt=%b, required 1", i_gnt);
    end
    fill_beats(1'b0, 2, 16'h9000);
    i_en = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    i_req = 1'b0; i_en = 1'b0; i_addr = '0;
    d_req = 1'b0; d_wr = 1'b0; d_en = 1'b0; d_addr = '0; d_wdata = '0;
    mem_rdata = '0; mem_data_valid = 1'b0;

    test_reset();
    test_priority();
    test_ifill();
    test_write();
    test_persist();
    test_rst_midfill();
    test_stray();

    repeat (2) @(negedge clk);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: pending=%0d, required 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
